nonce_dispatch_scheduler: RTL

Job scheduler that shares a pool of NUM_CORES SHA-256 Bitcoin hash cores across one nonce search. It issues nonces nonce_base, nonce_base+1, … round-robin to idle cores and tracks which nonce each core holds. It collects completions, compares each core's final h0 against target, stops issuing after the first hit, drains in-flight work, and reports the lowest winning nonce. It sits between the mining top level and the hash-core array.

---
 rtl/nonce_dispatch_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nonce_dispatch_scheduler.sv
// rtl/nonce_dispatch_scheduler.sv - round-robin nonce dispatcher and hit collector for a pool of SHA-256 cores
module nonce_dispatch_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            nonce_base,
    input  logic [CNT_W-1:0]       nonce_count,
    input  logic [31:0]            target,
    output logic [NUM_CORES-1:0]   core_start,
    output logic [31:0]            core_nonce,
    input  logic [NUM_CORES-1:0]   core_done,
    input  logic [32*NUM_CORES-1:0] core_h0,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [31:0]            found_nonce,
    output logic [31:0]            found_h0
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, REPORT} state_t;

    state_t                state, state_nx;
    logic [31:0]           base_q, target_q;
    logic [CNT_W-1:0]      count_q, issued;
    logic [NUM_CORES-1:0]  inflight;
    logic [31:0]           tag [NUM_CORES];
    logic [IDX_W-1:0]      rr_ptr, sel, probe;
    logic                  sel_valid, issue;
    logic [NUM_CORES-1:0]  issue_mask, retire, cand;
    logic                  best_valid;
    logic [31:0]           best_nonce, best_h0, next_nonce;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'((v >= NUM_CORES) ? v - NUM_CORES : v);
    endfunction

    assign next_nonce = base_q + 32'(issued);

    // Scan from rr_ptr upward; descending loop so the nearest free core wins.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        probe     = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            probe = wrap_idx(int'(rr_ptr) + k);
            if (!inflight[probe]) begin
                sel       = probe;
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        issue      = (state == DISPATCH) && (issued < count_q) && !found && !abort && sel_valid;
        issue_mask = '0;
        if (issue) begin
            issue_mask[sel] = 1'b1;
        end
    end

    // Completions from idle cores are dropped; hits are merged against the stored winner.
    always_comb begin
        retire     = core_done & inflight;
        cand       = '0;
        best_valid = found;
        best_nonce = found_nonce;
        best_h0    = found_h0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand[i] = retire[i] && (core_h0[32*i +: 32] < target_q);
            if (cand[i] && (!best_valid || tag[i] < best_nonce)) begin
                best_valid = 1'b1;
                best_nonce = tag[i];
                best_h0    = core_h0[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = DISPATCH;
            DISPATCH: if ((issued == count_q) || (|cand) || abort) state_nx = DRAIN;
            DRAIN:    if (inflight == '0) state_nx = REPORT;
            REPORT:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == REPORT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            base_q      <= '0;
            target_q    <= '0;
            count_q     <= '0;
            issued      <= '0;
            inflight    <= '0;
            rr_ptr      <= '0;
            core_start  <= '0;
            core_nonce  <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_h0    <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                tag[i] <= '0;
            end
        end else begin
            state      <= state_nx;
            core_start <= issue_mask;
            inflight   <= (inflight & ~retire) | issue_mask;
            if (state == IDLE && start) begin
                base_q      <= nonce_base;
                count_q     <= nonce_count;
                target_q    <= target;
                issued      <= '0;
                rr_ptr      <= '0;
                found       <= 1'b0;
                found_nonce <= '0;
                found_h0    <= '0;
            end else if (|cand) begin
                found       <= 1'b1;
                found_nonce <= best_nonce;
                found_h0    <= best_h0;
            end
            if (issue) begin
                core_nonce <= next_nonce;
                tag[sel]   <= next_nonce;
                issued     <= issued + 1'b1;
                rr_ptr     <= wrap_idx(int'(sel) + 1);
            end
        end
    end

endmodule
